// File: rtl/motor_pkg.sv
// Shared types and constants for the motor H-bridge driver.
//   state_t   : per-channel bridge FSM state
//   DUTY_W    : width of the duty command
//   CNT_W     : width of the shared PWM counter (holds 0..255 plus headroom
//               so duty values >= PWM_PERIOD compare as "always high")
//   DIR_FWD   : direction level meaning forward
//   EN_ACTIVE : enable level meaning "run" (enables are active-low)
package motor_pkg;

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_DEAD = 2'd1,
      S_FWD  = 2'd2,
      S_REV  = 2'd3
   } state_t;

   localparam int   DUTY_W    = 8;
   localparam int   CNT_W     = 9;
   localparam logic DIR_FWD   = 1'b1;
   localparam logic EN_ACTIVE = 1'b0;

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: direction FSM with dead time, PWM gating, registered
// bridge outputs and (optionally) a soft-start duty ramp.
// Optional feature: MOTOR_SOFTSTART_EN (ramps the effective duty up from 0).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   en_q, dir_q     : registered enable (active-low) and direction
//   duty_q          : registered duty command
//   pwm_cnt         : shared PWM frame counter
//   in1, in2        : bridge inputs (forward leg, reverse leg), registered
//   busy            : channel is in dead time, registered
module motor_channel
   import motor_pkg::*;
#(
   parameter int DEAD_CYCLES = 4,
   parameter int RAMP_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_q,
   input  logic              dir_q,
   input  logic [DUTY_W-1:0] duty_q,
   input  logic [CNT_W-1:0]  pwm_cnt,
   output logic              in1,
   output logic              in2,
   output logic              busy
);

   localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYCLES - 1);

   state_t            state_reg, state_next;
   logic [7:0]        dead_reg, dead_next;
   logic              dir_reg, dir_next;
   logic [DUTY_W-1:0] duty_eff;
   logic              pwm;
   logic              in1_next, in2_next, busy_next;

   // Zero-extended compare: a duty at or above the period never goes low.
   assign pwm = (pwm_cnt < {1'b0, duty_eff});

`ifdef MOTOR_SOFTSTART_EN
   localparam int                RAMP_W    = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
   localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);

   logic [RAMP_W-1:0] ramp_reg;
   logic [DUTY_W-1:0] eff_reg;
   logic              drive_now, drive_next;

   assign drive_now  = (state_reg == S_FWD) || (state_reg == S_REV);
   assign drive_next = (state_next == S_FWD) || (state_next == S_REV);

   // The ramp only advances once the channel is already driving, so the
   // first step lands RAMP_CYCLES clocks after drive starts.
   always_ff @(posedge clk) begin
      if (reset || !drive_next) begin
         eff_reg  <= '0;
         ramp_reg <= '0;
      end else if (drive_now) begin
         if (duty_q < eff_reg) begin
            eff_reg <= duty_q;
         end else if (ramp_reg == RAMP_LAST) begin
            ramp_reg <= '0;
            if (eff_reg < duty_q)
               eff_reg <= eff_reg + 1'b1;
         end else begin
            ramp_reg <= ramp_reg + 1'b1;
         end
      end
   end

   assign duty_eff = eff_reg;
`else
   assign duty_eff = duty_q;
`endif

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_OFF;
         dead_reg  <= '0;
         dir_reg   <= 1'b0;
         in1       <= 1'b0;
         in2       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_reg <= state_next;
         dead_reg  <= dead_next;
         dir_reg   <= dir_next;
         in1       <= in1_next;
         in2       <= in2_next;
         busy      <= busy_next;
      end
   end

   // Next-state logic; disable outranks any direction change.
   always_comb begin
      state_next = state_reg;
      dead_next  = dead_reg;
      dir_next   = dir_reg;
      if (en_q != EN_ACTIVE) begin
         state_next = S_OFF;
         dead_next  = '0;
      end else begin
         case (state_reg)
            S_OFF: begin
               dir_next   = dir_q;
               dead_next  = '0;
               state_next = S_DEAD;
            end
            S_DEAD: begin
               if (dir_q != dir_reg) begin
                  dir_next  = dir_q;
                  dead_next = '0;
               end else if (dead_reg == DEAD_LAST) begin
                  state_next = (dir_reg == DIR_FWD) ? S_FWD : S_REV;
               end else begin
                  dead_next = dead_reg + 8'd1;
               end
            end
            default: begin
               // S_FWD / S_REV: dir_reg holds the direction being driven.
               if (dir_q != dir_reg) begin
                  dir_next   = dir_q;
                  dead_next  = '0;
                  state_next = S_DEAD;
               end
            end
         endcase
      end
   end

   // Outputs decoded from the next state; only one leg can ever be selected.
   always_comb begin
      busy_next = (state_next == S_DEAD);
      in1_next  = (state_next == S_FWD) && pwm;
      in2_next  = (state_next == S_REV) && pwm;
   end

endmodule

// File: rtl/motor_bridge_driver.sv
// Dual-channel H-bridge driver for the bump-and-go controller.
// Registers the motor commands once, runs the shared PWM counter and feeds
// two identical motor_channel instances (index 0 = left, 1 = right).
// Optional feature: MOTOR_SOFTSTART_EN (per-channel soft-start duty ramp).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   len/ren               : left/right enable, active-low
//   ldir/rdir             : left/right direction, 1 = forward
//   duty                  : duty in PWM counts, shared by both channels
//   l_in1/l_in2, r_in1/r_in2 : bridge inputs (A = forward leg, B = reverse)
//   l_busy/r_busy         : channel in dead time
module motor_bridge_driver
   import motor_pkg::*;
#(
   parameter int PWM_PERIOD  = 256,
   parameter int DEAD_CYCLES = 4,
   parameter int RAMP_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              len,
   input  logic              ldir,
   input  logic              ren,
   input  logic              rdir,
   input  logic [DUTY_W-1:0] duty,
   output logic              l_in1,
   output logic              l_in2,
   output logic              r_in1,
   output logic              r_in2,
   output logic              l_busy,
   output logic              r_busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

   logic [1:0]        en_q, dir_q;
   logic [DUTY_W-1:0] duty_q;
   logic [CNT_W-1:0]  pwm_cnt;
   logic [1:0]        in1_v, in2_v, busy_v;

   // Input registers; enables park at the inactive level in reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         en_q   <= {2{~EN_ACTIVE}};
         dir_q  <= '0;
         duty_q <= '0;
      end else begin
         en_q   <= {ren, len};
         dir_q  <= {rdir, ldir};
         duty_q <= duty;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || pwm_cnt == CNT_LAST)
         pwm_cnt <= '0;
      else
         pwm_cnt <= pwm_cnt + 1'b1;
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      motor_channel #(
         .DEAD_CYCLES(DEAD_CYCLES),
         .RAMP_CYCLES(RAMP_CYCLES)
      ) u_ch (
         .clk    (clk),
         .reset  (reset),
         .en_q   (en_q[gi]),
         .dir_q  (dir_q[gi]),
         .duty_q (duty_q),
         .pwm_cnt(pwm_cnt),
         .in1    (in1_v[gi]),
         .in2    (in2_v[gi]),
         .busy   (busy_v[gi])
      );
   end

   assign l_in1  = in1_v[0];
   assign l_in2  = in2_v[0];
   assign l_busy = busy_v[0];
   assign r_in1  = in1_v[1];
   assign r_in2  = in2_v[1];
   assign r_busy = busy_v[1];

endmodule

// File: tb/tb_motor_bridge_driver.sv
// Testbench for motor_bridge_driver. Two instances share the same stimulus:
// dut_a (PWM_PERIOD 256, RAMP_CYCLES 64) and dut_b (PWM_PERIOD 200,
// RAMP_CYCLES 2), both with DEAD_CYCLES 4. A cycle-level reference model of
// both channels of both instances predicts every output pin.
module tb_motor_bridge_driver;

   localparam int DEAD   = 4;
   localparam int P_A    = 256;
   localparam int P_B    = 200;
   localparam int RAMP_A = 64;
   localparam int RAMP_B = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       len = 1'b1, ldir = 1'b1, ren = 1'b1, rdir = 1'b1;
   logic [7:0] duty = 8'd0;
   logic       a_l_in1, a_l_in2, a_r_in1, a_r_in2, a_l_busy, a_r_busy;
   logic       b_l_in1, b_l_in2, b_r_in1, b_r_in2, b_l_busy, b_r_busy;

   always #5 clk = ~clk;

   motor_bridge_driver #(.PWM_PERIOD(P_A), .DEAD_CYCLES(DEAD), .RAMP_CYCLES(RAMP_A)) dut_a (
      .clk(clk), .reset(reset), .len(len), .ldir(ldir), .ren(ren), .rdir(rdir), .duty(duty),
      .l_in1(a_l_in1), .l_in2(a_l_in2), .r_in1(a_r_in1), .r_in2(a_r_in2),
      .l_busy(a_l_busy), .r_busy(a_r_busy));

   motor_bridge_driver #(.PWM_PERIOD(P_B), .DEAD_CYCLES(DEAD), .RAMP_CYCLES(RAMP_B)) dut_b (
      .clk(clk), .reset(reset), .len(len), .ldir(ldir), .ren(ren), .rdir(rdir), .duty(duty),
      .l_in1(b_l_in1), .l_in2(b_l_in2), .r_in1(b_r_in1), .r_in2(b_r_in2),
      .l_busy(b_l_busy), .r_busy(b_r_busy));

   // Reference model. mode: 0 off, 1 dead time, 2 driving.
   // dead_rem counts the dead-time cycles still to be shown on busy.
   typedef struct {
      int mode;
      bit dir;
      int dead_rem;
      int eff;
      int rcnt;
   } ch_t;

   ch_t         ch[4];          // 0/1: dut_a left/right, 2/3: dut_b left/right
   bit          q_en[2], q_dir[2];
   int          q_duty;
   int          cnt[2];
   bit          o_in1[4], o_in2[4], o_busy[4];
   logic [11:0] exp_v, obs_v;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic tick();
      int  s, d, eff_used;
      bit  pwm;
`ifdef MOTOR_SOFTSTART_EN
      int  ramp;
      bit  prev_drive;
`endif
      @(posedge clk);
      if (reset) begin
         for (int c = 0; c < 4; c++) begin
            ch[c] = '{0, 1'b0, 0, 0, 0};
            o_in1[c] = 0; o_in2[c] = 0; o_busy[c] = 0;
         end
         q_en = '{1, 1}; q_dir = '{0, 0}; q_duty = 0; cnt = '{0, 0};
      end else begin
         for (int c = 0; c < 4; c++) begin
            s = c % 2;
            d = c / 2;
`ifdef MOTOR_SOFTSTART_EN
            ramp       = (d == 1) ? RAMP_B : RAMP_A;
            prev_drive = (ch[c].mode == 2);
            eff_used   = ch[c].eff;
`else
            eff_used   = q_duty;
`endif
            pwm = (cnt[d] < eff_used);
            if (q_en[s]) begin
               ch[c].mode = 0;
            end else if (ch[c].mode == 0) begin
               ch[c].dir = q_dir[s]; ch[c].mode = 1; ch[c].dead_rem = DEAD;
            end else if (ch[c].mode == 1) begin
               if (q_dir[s] != ch[c].dir) begin
                  ch[c].dir = q_dir[s]; ch[c].dead_rem = DEAD;
               end else if (ch[c].dead_rem == 0) begin
                  ch[c].mode = 2;
               end
            end else if (q_dir[s] != ch[c].dir) begin
               ch[c].dir = q_dir[s]; ch[c].mode = 1; ch[c].dead_rem = DEAD;
            end
            o_busy[c] = (ch[c].mode == 1);
            if (o_busy[c]) ch[c].dead_rem--;
            o_in1[c] = (ch[c].mode == 2) && ch[c].dir && pwm;
            o_in2[c] = (ch[c].mode == 2) && !ch[c].dir && pwm;
`ifdef MOTOR_SOFTSTART_EN
            if (ch[c].mode != 2) begin
               ch[c].eff = 0; ch[c].rcnt = 0;
            end else if (prev_drive) begin
               if (q_duty < ch[c].eff) ch[c].eff = q_duty;
               else if (ch[c].rcnt == ramp - 1) begin
                  ch[c].rcnt = 0;
                  if (ch[c].eff < q_duty) ch[c].eff++;
               end else ch[c].rcnt++;
            end
`endif
         end
         cnt[0] = (cnt[0] + 1) % P_A;
         cnt[1] = (cnt[1] + 1) % P_B;
         q_en[0] = len; q_en[1] = ren; q_dir[0] = ldir; q_dir[1] = rdir; q_duty = int'(duty);
      end
      exp_v = {o_in1[0], o_in2[0], o_in1[1], o_in2[1], o_busy[0], o_busy[1],
               o_in1[2], o_in2[2], o_in1[3], o_in2[3], o_busy[2], o_busy[3]};
      #1;
      obs_v = {a_l_in1, a_l_in2, a_r_in1, a_r_in2, a_l_busy, a_r_busy,
               b_l_in1, b_l_in2, b_r_in1, b_r_in2, b_l_busy, b_r_busy};
   endtask

   task automatic test_reset();
      len = 1'b0; ldir = 1'b1; ren = 1'b0; rdir = 1'b0; duty = 8'd100;
      for (int i = 0; i < 30; i++) begin
         tick(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_run: got=%b want=%b", obs_v, exp_v); end
      end
      reset = 1'b1;
      tick(); n_checks++;
      if (obs_v !== 12'd0) begin n_fail++; $display("FAIL reset_clear: got=%b want=0", obs_v); end
      tick(); n_checks++;
      if (obs_v !== 12'd0) begin n_fail++; $display("FAIL reset_hold: got=%b want=0", obs_v); end
      len = 1'b1; ren = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(); n_checks++;
         if (obs_v !== 12'd0 || obs_v !== exp_v) begin n_fail++; $display("FAIL reset_off: got=%b want=0", obs_v); end
      end
   endtask

   task automatic test_forward();
      int nbusy = 0, nhi = 0, nin2 = 0;
      duty = 8'd128; ldir = 1'b1; len = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL fwd_start: got=%b want=%b", obs_v, exp_v); end
         nbusy += int'(a_l_busy);
      end
      n_checks++;
      if (nbusy !== DEAD) begin n_fail++; $display("FAIL fwd_dead_len: got=%0d want=%0d", nbusy, DEAD); end
      for (int i = 0; i < P_A; i++) begin
         tick(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL fwd_pwm: got=%b want=%b", obs_v, exp_v); end
         nhi += int'(a_l_in1); nin2 += int'(a_l_in2);
      end
      n_checks++;
      if (nin2 !== 0) begin n_fail++; $display("FAIL fwd_in2: got=%0d want=0", nin2); end
`ifndef MOTOR_SOFTSTART_EN
      n_checks++;
      if (nhi !== 128) begin n_fail++; $display("FAIL fwd_duty: got=%0d want=128", nhi); end
`endif
   endtask

   task automatic test_reverse();
      int nbusy = 0, ndrv = 0, nin1 = 0, nin2 = 0;
      ldir = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL rev_switch: got=%b want=%b", obs_v, exp_v); end
         nbusy += int'(a_l_busy);
         if (a_l_busy && (a_l_in1 || a_l_in2)) ndrv++;
      end
      n_checks++;
      if (nbusy !== DEAD || ndrv !== 0) begin
         n_fail++; $display("FAIL rev_dead: busy=%0d drive_in_dead=%0d want %0d and 0", nbusy, ndrv, DEAD);
      end
      for (int i = 0; i < P_A; i++) begin
         tick(); n_checks++;
         if (obs_v !== exp_v || (a_l_in1 && a_l_in2)) begin n_fail++; $display("FAIL rev_pwm: got=%b want=%b", obs_v, exp_v); end
         nin1 += int'(a_l_in1); nin2 += int'(a_l_in2);
      end
      n_checks++;
      if (nin1 !== 0) begin n_fail++; $display("FAIL rev_in1: got=%0d want=0", nin1); end
`ifndef MOTOR_SOFTSTART_EN
      n_checks++;
      if (nin2 !== 128) begin n_fail++; $display("FAIL rev_duty: got=%0d want=128", nin2); end
`endif
   endtask

   task automatic test_duty_edges();
      int nhi = 0, nlo = 0;
      ldir = 1'b1; duty = 8'd0;
      for (int i = 0; i < 310; i++) begin
         tick(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL duty0: got=%b want=%b", obs_v, exp_v); end
         if (i >= 10) nhi += int'(a_l_in1) + int'(b_l_in1);
      end
      n_checks++;
      if (nhi !== 0) begin n_fail++; $display("FAIL duty0_low: highs=%0d want=0", nhi); end
      duty = 8'd250;
      for (int i = 0; i < 403; i++) begin
         tick(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL duty_sat: got=%b want=%b", obs_v, exp_v); end
         if (i >= 3 && !b_l_in1) nlo++;
      end
`ifndef MOTOR_SOFTSTART_EN
      n_checks++;
      if (nlo !== 0) begin n_fail++; $display("FAIL duty_sat_high: lows=%0d want=0", nlo); end
`endif
   endtask

   task automatic test_abort();
      int nbusy = 0;
      len = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL abort_off: got=%b want=%b", obs_v, exp_v); end
      end
      len = 1'b0;
      tick(); tick(); tick();   // third tick shows the second dead-time cycle
      n_checks++;
      if (a_l_busy !== 1'b1 || obs_v !== exp_v) begin n_fail++; $display("FAIL abort_dead2: busy=%b want=1", a_l_busy); end
      len = 1'b1;
      tick(); n_checks++;
      if (a_l_busy !== 1'b1) begin n_fail++; $display("FAIL abort_lat1: busy=%b want=1", a_l_busy); end
      tick(); n_checks++;
      if ({a_l_busy, a_l_in1, a_l_in2} !== 3'b000 || obs_v !== exp_v) begin
         n_fail++; $display("FAIL abort_lat2: busy/in1/in2=%b want=000", {a_l_busy, a_l_in1, a_l_in2});
      end
      len = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(); n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL abort_restart: got=%b want=%b", obs_v, exp_v); end
         nbusy += int'(a_l_busy);
      end
      n_checks++;
      if (nbusy !== DEAD) begin n_fail++; $display("FAIL abort_full_dead: got=%0d want=%0d", nbusy, DEAD); end
   endtask

`ifdef MOTOR_SOFTSTART_EN
   task automatic test_softstart();
      int k = 0;
      len = 1'b1; duty = 8'd10;
      tick(); tick(); tick();
      len = 1'b0;
      tick(); tick();
      while (b_l_busy && k < 50) begin tick(); k++; end
      n_checks++;
      if (b_l_busy) begin n_fail++; $display("FAIL soft_entry: timeout busy=%b", b_l_busy); end
      k = 0;
      while (dut_b.g_ch[0].u_ch.duty_eff != 8'd10 && k < 100) begin
         tick(); k++;
         n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL soft_ramp: got=%b want=%b", obs_v, exp_v); end
      end
      n_checks++;
      if (k !== 20) begin n_fail++; $display("FAIL soft_ramp_time: got=%0d want=20", k); end
      duty = 8'd3;
      tick(); n_checks++;
      if (dut_b.g_ch[0].u_ch.duty_eff !== 8'd10) begin n_fail++; $display("FAIL soft_hold: got=%0d want=10", dut_b.g_ch[0].u_ch.duty_eff); end
      tick(); n_checks++;
      if (dut_b.g_ch[0].u_ch.duty_eff !== 8'd3) begin n_fail++; $display("FAIL soft_drop: got=%0d want=3", dut_b.g_ch[0].u_ch.duty_eff); end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) len  = ~len;
         if ($urandom_range(0, 19) == 0) ldir = ~ldir;
         if ($urandom_range(0, 19) == 0) ren  = ~ren;
         if ($urandom_range(0, 19) == 0) rdir = ~rdir;
         if ($urandom_range(0, 49) == 0) duty = 8'($urandom_range(0, 255));
         reset = ($urandom_range(0, 599) == 0);
         tick(); n_checks++;
         if (obs_v !== exp_v || (a_l_in1 && a_l_in2) || (b_r_in1 && b_r_in2)) begin
            n_fail++; $display("FAIL random[%0d]: got=%b want=%b", i, obs_v, exp_v);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      test_reset();
      test_forward();
      test_reverse();
      test_duty_edges();
      test_abort();
`ifdef MOTOR_SOFTSTART_EN
      test_softstart();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
